// File: rtl/frame_ser_pkg.sv
`default_nettype none
// ============================================================================
// Module   : frame_ser_pkg
// Brief    : Shared state encoding and index-width helper for frame_serializer
// Revision : 1.0
// ============================================================================
package frame_ser_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   // Index port never collapses to zero width, even for single-word frames.
   function automatic int idx_w(input int channel);
      return (channel > 1) ? $clog2(channel) : 1;
   endfunction

endpackage : frame_ser_pkg
`default_nettype wire

// File: rtl/frame_shift_reg.sv
`default_nettype none
// ============================================================================
// Module   : frame_shift_reg
// Brief    : Frame holding register with load / shift-left-by-WIDTH / hold
// Revision : 1.0  (WORD_PARITY_EN adds the word_next port)
// ============================================================================
module frame_shift_reg #(
   parameter int WIDTH   = 32,
   parameter int CHANNEL = 10
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       load,
   input  logic                       shift,
   input  logic [CHANNEL*WIDTH-1:0]   din,
   output logic [WIDTH-1:0]           word_top
`ifdef WORD_PARITY_EN
   ,
   output logic [WIDTH-1:0]           word_next
`endif
);

   localparam int c_frame_w = CHANNEL * WIDTH;

   logic [c_frame_w-1:0] r_frame;
   logic [c_frame_w-1:0] w_shifted;

   generate
      if (CHANNEL > 1) begin : g_multi
         assign w_shifted = {r_frame[c_frame_w-WIDTH-1:0], {WIDTH{1'b0}}};
`ifdef WORD_PARITY_EN
         assign word_next = r_frame[c_frame_w-WIDTH-1 -: WIDTH];
`endif
      end else begin : g_single
         // A single-word frame never shifts; the last transfer always reloads or idles.
         assign w_shifted = '0;
`ifdef WORD_PARITY_EN
         assign word_next = '0;
`endif
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         r_frame <= '0;
      end else if (load) begin
         r_frame <= din;
      end else if (shift) begin
         r_frame <= w_shifted;
      end
   end

   assign word_top = r_frame[c_frame_w-1 -: WIDTH];

endmodule : frame_shift_reg
`default_nettype wire

// File: rtl/frame_serializer.sv
`default_nettype none
// ============================================================================
// Module   : frame_serializer
// Brief    : Unloads a packed CHANNEL-word frame one word per cycle, oldest
//            word (CHANNEL-1) first, on a valid/ready stream.
//            Optional macro WORD_PARITY_EN adds the registered out_par output.
// Revision : 1.0
// ============================================================================
module frame_serializer
   import frame_ser_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int CHANNEL = 10
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [CHANNEL*WIDTH-1:0]        frame_in,
   input  logic                            frame_valid,
   output logic                            frame_ready,
   output logic [WIDTH-1:0]                out,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic                            out_last,
   output logic [idx_w(CHANNEL)-1:0]       out_idx
`ifdef WORD_PARITY_EN
   ,
   output logic                            out_par
`endif
);

   localparam int                c_idx_w    = idx_w(CHANNEL);
   localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(CHANNEL - 1);
   localparam logic [c_idx_w-1:0] c_idx_one  = c_idx_w'(1);

   state_t             r_state;
   logic [c_idx_w-1:0] r_idx;
   logic               r_out_valid;
   logic               r_out_last;

   logic               w_xfer;
   logic               w_last_xfer;
   logic               w_shift;
   logic               w_ready;
   logic               w_accept;
   logic [WIDTH-1:0]   w_top_word;

   assign w_xfer      = r_out_valid && out_ready;
   assign w_last_xfer = w_xfer && r_out_last;
   assign w_shift     = w_xfer && !r_out_last;
   // Ready on the final word's transfer cycle lets frames stream with no bubble.
   assign w_ready     = !rst && ((r_state == IDLE) || w_last_xfer);
   assign w_accept    = frame_valid && w_ready;

   assign frame_ready = w_ready;

`ifdef WORD_PARITY_EN
   logic [WIDTH-1:0] w_next_word;
   logic [WIDTH-1:0] w_par_src;
   logic             r_out_par;

   assign w_par_src = w_accept ? frame_in[CHANNEL*WIDTH-1 -: WIDTH] : w_next_word;
`endif

   frame_shift_reg #(
      .WIDTH   (WIDTH),
      .CHANNEL (CHANNEL)
   ) u_shift (
      .clk       (clk),
      .rst       (rst),
      .load      (w_accept),
      .shift     (w_shift),
      .din       (frame_in),
      .word_top  (w_top_word)
`ifdef WORD_PARITY_EN
      ,
      .word_next (w_next_word)
`endif
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_idx       <= '0;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
`ifdef WORD_PARITY_EN
         r_out_par   <= 1'b0;
`endif
      end else if (w_accept) begin
         r_state     <= SEND;
         r_idx       <= c_last_idx;
         r_out_valid <= 1'b1;
         r_out_last  <= (CHANNEL == 1);
`ifdef WORD_PARITY_EN
         r_out_par   <= ^w_par_src;
`endif
      end else if (w_last_xfer) begin
         r_state     <= IDLE;
         r_out_valid <= 1'b0;
      end else if (w_shift) begin
         r_idx       <= r_idx - c_idx_one;
         r_out_last  <= (r_idx == c_idx_one);
`ifdef WORD_PARITY_EN
         r_out_par   <= ^w_par_src;
`endif
      end
   end

   assign out       = w_top_word;
   assign out_valid = r_out_valid;
   assign out_last  = r_out_last;
   assign out_idx   = r_idx;
`ifdef WORD_PARITY_EN
   assign out_par   = r_out_par;
`endif

endmodule : frame_serializer
`default_nettype wire

// File: tb/tb_frame_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_frame_serializer
// Brief    : Directed self-checking bench for frame_serializer (CHANNEL=10 and 1)
// Revision : 1.0
// ============================================================================
module tb_frame_serializer;

   localparam int W = 32;
   localparam int C = 10;

   logic           clk = 1'b0;
   logic           rst;
   logic [C*W-1:0] frame_in;
   logic           frame_valid;
   logic           frame_ready;
   logic [W-1:0]   out;
   logic           out_valid;
   logic           out_ready;
   logic           out_last;
   logic [3:0]     out_idx;

   logic [W-1:0]   f1_in;
   logic           f1_valid;
   logic           f1_ready;
   logic [W-1:0]   o1;
   logic           o1_valid;
   logic           o1_ready;
   logic           o1_last;
   logic [0:0]     o1_idx;
`ifdef WORD_PARITY_EN
   logic           par;
   logic           par1;
`endif

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   frame_serializer #(.WIDTH(W), .CHANNEL(C)) dut (
      .clk         (clk),
      .rst         (rst),
      .frame_in    (frame_in),
      .frame_valid (frame_valid),
      .frame_ready (frame_ready),
      .out         (out),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_last    (out_last),
      .out_idx     (out_idx)
`ifdef WORD_PARITY_EN
      ,
      .out_par     (par)
`endif
   );

   frame_serializer #(.WIDTH(W), .CHANNEL(1)) dut1 (
      .clk         (clk),
      .rst         (rst),
      .frame_in    (f1_in),
      .frame_valid (f1_valid),
      .frame_ready (f1_ready),
      .out         (o1),
      .out_valid   (o1_valid),
      .out_ready   (o1_ready),
      .out_last    (o1_last),
      .out_idx     (o1_idx)
`ifdef WORD_PARITY_EN
      ,
      .out_par     (par1)
`endif
   );

   function automatic logic [C*W-1:0] mk(input logic [W-1:0] base);
      logic [C*W-1:0] f;
      for (int k = 0; k < C; k++) f[k*W +: W] = base + W'(k);
      return f;
   endfunction

   task automatic test_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      n_vec++;
      if (out !== '0 || out_valid !== 1'b0 || out_last !== 1'b0 || out_idx !== 4'd0) begin
         n_err++;
         $display("FAIL reset_outputs: got out=%h v=%b l=%b i=%0d want 0/0/0/0", out, out_valid, out_last, out_idx);
      end
      n_vec++;
      if (frame_ready !== 1'b0 || f1_ready !== 1'b0) begin
         n_err++;
         $display("FAIL reset_frame_ready: got %b/%b want 0/0", frame_ready, f1_ready);
      end
      rst = 1'b0;
      #1;
      n_vec++;
      if (frame_ready !== 1'b1) begin
         n_err++;
         $display("FAIL idle_frame_ready: got %b want 1", frame_ready);
      end
   endtask

   task automatic test_basic_order();
      logic [C*W-1:0] f;
      logic [C*W-1:0] packed_frame;
      f = mk(32'hA000_0000);
      packed_frame = '0;
      @(negedge clk);
      frame_in = f; frame_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      frame_valid = 1'b0;
      for (int k = C - 1; k >= 0; k--) begin
         n_vec++;
         if (out_valid !== 1'b1 || out !== 32'hA000_0000 + k || out_idx !== 4'(k) || out_last !== (k == 0)) begin
            n_err++;
            $display("FAIL basic_word k=%0d: got out=%h v=%b i=%0d l=%b want %h/1/%0d/%b",
                     k, out, out_valid, out_idx, out_last, 32'hA000_0000 + k, k, (k == 0));
         end
         packed_frame = {packed_frame[C*W-W-1:0], out};
         @(posedge clk);
         @(negedge clk);
      end
      n_vec++;
      if (out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL basic_idle_after: got out_valid=%b want 0", out_valid);
      end
      n_vec++;
      if (packed_frame !== f) begin
         n_err++;
         $display("FAIL round_trip: got %h want %h", packed_frame, f);
      end
   endtask

   task automatic test_backpressure();
      @(negedge clk);
      frame_in = mk(32'hA000_0000); frame_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      frame_valid = 1'b0;
      for (int k = C - 1; k >= 0; k--) begin
         if (k == 6) begin
            out_ready = 1'b0;
            frame_valid = 1'b1;
            frame_in = mk(32'hB000_0000);
            for (int s = 0; s < 3; s++) begin
               #1;
               n_vec++;
               if (out !== 32'hA000_0006 || out_idx !== 4'd6 || out_valid !== 1'b1 || out_last !== 1'b0 || frame_ready !== 1'b0) begin
                  n_err++;
                  $display("FAIL stall s=%0d: got out=%h i=%0d v=%b l=%b fr=%b want a0000006/6/1/0/0",
                           s, out, out_idx, out_valid, out_last, frame_ready);
               end
               @(posedge clk);
               @(negedge clk);
            end
            out_ready = 1'b1;
            frame_valid = 1'b0;
         end
         n_vec++;
         if (out_valid !== 1'b1 || out !== 32'hA000_0000 + k || out_idx !== 4'(k)) begin
            n_err++;
            $display("FAIL bp_word k=%0d: got out=%h v=%b i=%0d want %h/1/%0d",
                     k, out, out_valid, out_idx, 32'hA000_0000 + k, k);
         end
         @(posedge clk);
         @(negedge clk);
      end
      n_vec++;
      if (out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL bp_idle_after: got out_valid=%b want 0", out_valid);
      end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      frame_in = mk(32'hA000_0000); frame_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      frame_in = mk(32'hB000_0000);
      for (int k = C - 1; k >= 0; k--) begin
         #1;
         n_vec++;
         if (out_valid !== 1'b1 || out !== 32'hA000_0000 + k || frame_ready !== (k == 0)) begin
            n_err++;
            $display("FAIL b2b_first k=%0d: got out=%h v=%b fr=%b want %h/1/%b",
                     k, out, out_valid, frame_ready, 32'hA000_0000 + k, (k == 0));
         end
         @(posedge clk);
         @(negedge clk);
      end
      frame_valid = 1'b0;
      for (int k = C - 1; k >= 0; k--) begin
         n_vec++;
         if (out_valid !== 1'b1 || out !== 32'hB000_0000 + k || out_idx !== 4'(k)) begin
            n_err++;
            $display("FAIL b2b_second k=%0d: got out=%h v=%b i=%0d want %h/1/%0d",
                     k, out, out_valid, out_idx, 32'hB000_0000 + k, k);
         end
         @(posedge clk);
         @(negedge clk);
      end
      n_vec++;
      if (out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL b2b_idle_after: got out_valid=%b want 0", out_valid);
      end
   endtask

   task automatic test_reset_mid_frame();
      @(negedge clk);
      frame_in = mk(32'hA000_0000); frame_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      frame_valid = 1'b0;
      repeat (5) begin
         @(posedge clk);
         @(negedge clk);
      end
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      n_vec++;
      if (out_valid !== 1'b0 || out !== '0 || out_idx !== 4'd0 || out_last !== 1'b0) begin
         n_err++;
         $display("FAIL mid_reset: got out=%h v=%b i=%0d l=%b want 0/0/0/0", out, out_valid, out_idx, out_last);
      end
      frame_in = mk(32'hC000_0000); frame_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      frame_valid = 1'b0;
      n_vec++;
      if (out_valid !== 1'b1 || out !== 32'hC000_0009 || out_idx !== 4'd9) begin
         n_err++;
         $display("FAIL post_reset_first: got out=%h v=%b i=%0d want c0000009/1/9", out, out_valid, out_idx);
      end
      repeat (C) begin
         @(posedge clk);
         @(negedge clk);
      end
      n_vec++;
      if (out_valid !== 1'b0 || out !== 32'hC000_0000) begin
         n_err++;
         $display("FAIL post_reset_drain: got out=%h v=%b want c0000000/0", out, out_valid);
      end
   endtask

   task automatic test_single_channel();
      @(negedge clk);
      f1_in = 32'h0000_0007; f1_valid = 1'b1; o1_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      f1_in = 32'h0000_0003;
      #1;
      n_vec++;
      if (o1_valid !== 1'b1 || o1 !== 32'h0000_0007 || o1_last !== 1'b1 || o1_idx !== 1'b0 || f1_ready !== 1'b1) begin
         n_err++;
         $display("FAIL ch1_first: got out=%h v=%b l=%b i=%0d fr=%b want 00000007/1/1/0/1",
                  o1, o1_valid, o1_last, o1_idx, f1_ready);
      end
`ifdef WORD_PARITY_EN
      n_vec++;
      if (par1 !== 1'b1) begin
         n_err++;
         $display("FAIL ch1_par_first: got %b want 1", par1);
      end
`endif
      @(posedge clk);
      @(negedge clk);
      f1_valid = 1'b0;
      n_vec++;
      if (o1_valid !== 1'b1 || o1 !== 32'h0000_0003 || o1_last !== 1'b1 || o1_idx !== 1'b0) begin
         n_err++;
         $display("FAIL ch1_second: got out=%h v=%b l=%b i=%0d want 00000003/1/1/0", o1, o1_valid, o1_last, o1_idx);
      end
`ifdef WORD_PARITY_EN
      n_vec++;
      if (par1 !== 1'b0) begin
         n_err++;
         $display("FAIL ch1_par_second: got %b want 0", par1);
      end
`endif
      @(posedge clk);
      @(negedge clk);
      n_vec++;
      if (o1_valid !== 1'b0) begin
         n_err++;
         $display("FAIL ch1_idle_after: got out_valid=%b want 0", o1_valid);
      end
   endtask

   initial begin
      rst = 1'b1;
      frame_in = '0; frame_valid = 1'b0; out_ready = 1'b0;
      f1_in = '0; f1_valid = 1'b0; o1_ready = 1'b0;
      test_reset();
      test_basic_order();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_frame();
      test_single_channel();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_frame_serializer
`default_nettype wire
